// File: rtl/dac_frontend_pkg.sv
// Shared types and constants for the DAC front end: envelope FSM state encoding and
// the dither LFSR definition (x^8+x^6+x^5+x^4+1, Fibonacci, shift toward MSB).
package dac_frontend_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        ACTIVE    = 2'd2,
        RAMP_DOWN = 2'd3
    } env_state_t;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    // Taps at polynomial terms 8,6,5,4 map to state bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_step(input logic [7:0] state);
        return {state[6:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dac_frontend_requant.sv
// dac_requant: one channel of the second pipeline stage. Adds the rounding (or dither) term,
// drops IN_W-DAC_W LSBs arithmetically, saturates and converts to offset binary.
module dac_requant
    import dac_frontend_pkg::*;
#(
    parameter int IN_W  = 9,
    parameter int DAC_W = 6
) (
    input  logic [IN_W-1:0]       prod,
    input  logic [IN_W-DAC_W-1:0] rnd,
    output logic [DAC_W-1:0]      code,
    output logic                  clip
);

    localparam int SH = IN_W - DAC_W;
    localparam logic [DAC_W-1:0] MSB_MASK = DAC_W'(2 ** (DAC_W - 1));

    logic [IN_W:0]  sum;
    logic [DAC_W:0] q;

    always_comb begin
        // One guard bit so +max plus the rounding term cannot wrap
        sum  = {prod[IN_W-1], prod} + {{(DAC_W + 1){1'b0}}, rnd};
        q    = (DAC_W + 1)'(sum >> SH);
        clip = 1'b0;
        code = q[DAC_W-1:0] ^ MSB_MASK;
        if (q[DAC_W] != q[DAC_W-1]) begin
            clip = 1'b1;
            code = q[DAC_W] ? '0 : '1;
        end
    end

endmodule

// File: rtl/dac_frontend.sv
// dac_frontend: hold regs, ramp envelope FSM, envelope multiply and per-channel requantisers
// feeding the DACs, plus the RF chain enable. Define DAC_DITHER_EN for LFSR dithered rounding.
module dac_frontend
    import dac_frontend_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int IN_W      = 9,
    parameter int DAC_W     = 6,
    parameter int RAMP_LOG2 = 3
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    sample_strobe,
    input  logic                    iq_valid,
    input  logic [NUM_CH*IN_W-1:0]  in_data,
    output logic [NUM_CH*DAC_W-1:0] dac_out,
    output logic                    txchain_en,
    output logic [NUM_CH-1:0]       clip_seen
);

    localparam int ENV_W  = RAMP_LOG2 + 1;
    localparam int SH     = IN_W - DAC_W;
    localparam int PROD_W = IN_W + ENV_W + 1;
    localparam logic [ENV_W-1:0] ENV_MAX  = ENV_W'(2 ** RAMP_LOG2);
    localparam logic [DAC_W-1:0] MIDSCALE = DAC_W'(2 ** (DAC_W - 1));

    env_state_t       state_reg, state_next;
    logic [ENV_W-1:0] env_reg, env_next, env_up, env_dn;
    logic             idle_age_reg, idle_age_next;
    logic             txchain_next;
    logic [SH-1:0]    rnd;

    always_comb begin
        env_up        = env_reg + 1'b1;
        env_dn        = env_reg - 1'b1;
        state_next    = state_reg;
        env_next      = env_reg;
        idle_age_next = 1'b0;
        txchain_next  = txchain_en;
        unique case (state_reg)
            IDLE: begin
                if (iq_valid) begin
                    env_next     = env_up;
                    state_next   = (env_up == ENV_MAX) ? ACTIVE : RAMP_UP;
                    txchain_next = 1'b1;
                end else begin
                    // Second idle strobe: the zero-envelope product has reached dac_out
                    idle_age_next = 1'b1;
                    if (idle_age_reg) begin
                        txchain_next = 1'b0;
                    end
                end
            end
            RAMP_UP, RAMP_DOWN: begin
                if (iq_valid) begin
                    env_next   = env_up;
                    state_next = (env_up == ENV_MAX) ? ACTIVE : RAMP_UP;
                end else begin
                    env_next   = env_dn;
                    state_next = (env_dn == '0) ? IDLE : RAMP_DOWN;
                end
            end
            ACTIVE: begin
                if (!iq_valid) begin
                    env_next   = env_dn;
                    state_next = (env_dn == '0) ? IDLE : RAMP_DOWN;
                end
            end
            default: begin
                state_next = IDLE;
                env_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            env_reg      <= '0;
            idle_age_reg <= 1'b0;
            txchain_en   <= 1'b0;
        end else if (sample_strobe) begin
            state_reg    <= state_next;
            env_reg      <= env_next;
            idle_age_reg <= idle_age_next;
            txchain_en   <= txchain_next;
        end
    end

`ifdef DAC_DITHER_EN
    logic [7:0] lfsr_reg;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lfsr_reg <= LFSR_SEED;
        end else if (sample_strobe) begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    assign rnd = SH'(lfsr_reg);
`else
    assign rnd = SH'(2 ** (SH - 1));
`endif

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic signed [IN_W-1:0]   hold_reg;
        logic signed [IN_W-1:0]   p_reg;
        logic signed [PROD_W-1:0] prod_full;
        logic [DAC_W-1:0]         dac_reg;
        logic [DAC_W-1:0]         code;
        logic                     clip;
        logic                     clip_reg;

        // |hold * env / 2**RAMP_LOG2| <= |hold|, so the shifted product fits IN_W bits
        assign prod_full = hold_reg * $signed({1'b0, env_reg});

        dac_requant #(
            .IN_W  (IN_W),
            .DAC_W (DAC_W)
        ) u_requant (
            .prod (p_reg),
            .rnd  (rnd),
            .code (code),
            .clip (clip)
        );

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                hold_reg <= '0;
                p_reg    <= '0;
                dac_reg  <= MIDSCALE;
                clip_reg <= 1'b0;
            end else if (sample_strobe) begin
                if (iq_valid) begin
                    hold_reg <= in_data[gi*IN_W +: IN_W];
                end
                p_reg   <= IN_W'(prod_full >>> RAMP_LOG2);
                dac_reg <= code;
                if (clip) begin
                    clip_reg <= 1'b1;
                end
            end
        end

        assign dac_out[gi*DAC_W +: DAC_W] = dac_reg;
        assign clip_seen[gi]              = clip_reg;
    end

endmodule
